// File: rtl/load_ext_pipe_pkg.sv
// Shared types and helpers for the load-extension pipeline.
// Defines the load-type encoding and the access-size lookup used by the extender.
package ext_pkg;

  localparam int EXT_MODE_W = 3;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_B   = 3'd0,
    EXT_BU  = 3'd1,
    EXT_H   = 3'd2,
    EXT_HU  = 3'd3,
    EXT_W   = 3'd4,
    EXT_WU  = 3'd5,
    EXT_D   = 3'd6,
    EXT_RSV = 3'd7
  } ext_mode_e;

  // Byte count of the field a load type reads; the reserved code reports 0
  // and is rejected separately by the extender.
  function automatic int unsigned size_of(input ext_mode_e mode, input int unsigned data_w);
    case (mode)
      EXT_B, EXT_BU: size_of = 1;
      EXT_H, EXT_HU: size_of = 2;
      EXT_W, EXT_WU: size_of = 4;
      EXT_D:         size_of = data_w / 8;
      default:       size_of = 0;
    endcase
  endfunction

endpackage

// File: rtl/load_ext_pipe_core.sv
// Combinational load extender: picks the addressed byte/half/word/double out of
// a little-endian memory word and sign- or zero-extends it to DATA_W.
// Misaligned, oversized or reserved accesses raise err and force data_out to 0.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [OFF_W-1:0]  off,
  input  ext_mode_e         mode,
  output logic [DATA_W-1:0] data_out,
  output logic              err
);

  localparam int unsigned BYTES = DATA_W / 8;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic [OFF_W-1:0]  align_mask;
  int unsigned       size;
  logic              misaligned;
  logic              oversize;

  // Shift the addressed byte down to bit 0, validate the access, then extend.
  always_comb begin
    size       = size_of(mode, BYTES * 8);
    shifted    = data_in >> {off, 3'b000};
    align_mask = OFF_W'(size - 1);
    misaligned = (off & align_mask) != '0;
    oversize   = size > BYTES;
    err        = (mode == EXT_RSV) || misaligned || oversize;

    ext = '0;
    case (mode)
      EXT_B:   ext = DATA_W'($signed(shifted[7:0]));
      EXT_BU:  ext = DATA_W'(shifted[7:0]);
      EXT_H:   ext = DATA_W'($signed(shifted[15:0]));
      EXT_HU:  ext = DATA_W'(shifted[15:0]);
      EXT_W:   ext = DATA_W'($signed(shifted[31:0]));
      EXT_WU:  ext = DATA_W'(shifted[31:0]);
      EXT_D:   ext = shifted;
      default: ext = '0;
    endcase

    data_out = err ? '0 : ext;
  end

endmodule

// File: rtl/load_ext_pipe.sv
// Registered load extender between the data-memory read port and MEM/WB.
// One output register plus a single skid entry keep in_ready purely registered,
// so a downstream stall never reaches the memory side combinationally.
module load_ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [OFF_W-1:0]      in_off,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_err
);

  logic [DATA_W-1:0] core_data;
  logic              core_err;
  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;
  logic              accept;
  logic              out_free;

  ext_core #(.DATA_W(DATA_W)) u_core (
    .data_in  (in_data),
    .off      (in_off),
    .mode     (ext_mode_e'(in_mode)),
    .data_out (core_data),
    .err      (core_err)
  );

  // Handshake qualifiers: a beat is taken when offered and we are ready, and
  // the output register can be reloaded when empty or being drained this edge.
  always_comb begin
    accept   = in_valid && in_ready;
    out_free = !out_valid || out_ready;
  end

  // Output register and skid entry; the skid always drains first to keep order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (out_free) begin
        if (skid_full) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_err   <= skid_err;
          skid_full <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= core_data;
          out_err   <= core_err;
        end else begin
          out_valid <= 1'b0;
        end
        in_ready <= 1'b1;
      end else begin
        if (accept) begin
          skid_full <= 1'b1;
          skid_data <= core_data;
          skid_err  <= core_err;
        end
        in_ready <= !(skid_full || accept);
      end
    end
  end

endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench for load_ext_pipe: one 32-bit and one 64-bit instance.
// Stimulus pushes expected beats into per-instance queues; a monitor on the
// falling edge pops and compares every delivered beat and checks stall stability.
module tb_load_ext_pipe;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [1:0]  out_err;
  logic [63:0] in_data [2];
  logic [2:0]  in_off  [2];
  logic [2:0]  in_mode [2];
  logic [31:0] out_data32;
  logic [63:0] out_data64;
  int          ready_mode [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int total_checks  = 0;
  int passed_checks = 0;

  logic        hold      [2];
  logic [63:0] hold_data [2];
  logic        hold_err  [2];

  always #5 clk = ~clk;

  load_ext_pipe #(.DATA_W(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0][31:0]),
    .in_off    (in_off[0][1:0]),
    .in_mode   (in_mode[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data32),
    .out_err   (out_err[0])
  );

  load_ext_pipe #(.DATA_W(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .in_off    (in_off[1]),
    .in_mode   (in_mode[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data64),
    .out_err   (out_err[1])
  );

  function automatic exp_t mk(input logic [63:0] d, input logic e);
    exp_t r;
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  function automatic logic [63:0] outData(input int u);
    return (u == 0) ? {32'h0, out_data32} : out_data64;
  endfunction

  function automatic int modeSize(input int mode, input int dw);
    case (mode)
      0, 1:    return 1;
      2, 3:    return 2;
      4, 5:    return 4;
      6:       return dw / 8;
      default: return 0;
    endcase
  endfunction

  // Reference: select bytes arithmetically, then extend by masking and OR-ing.
  function automatic exp_t model(input logic [63:0] d_in, input int off, input int mode, input int dw);
    logic [63:0] d;
    logic [63:0] field;
    logic [63:0] mask;
    int          size;
    bit          sgn;
    d = (dw == 32) ? (d_in & 64'hFFFF_FFFF) : d_in;
    if (mode == 7) return mk(64'h0, 1'b1);
    size = modeSize(mode, dw);
    if (size > dw / 8 || (off % size) != 0) return mk(64'h0, 1'b1);
    sgn   = (mode == 0) || (mode == 2) || (mode == 4);
    field = d >> (8 * off);
    mask  = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    field = field & mask;
    if (sgn && field[8 * size - 1]) field = field | ~mask;
    if (dw == 32) field = field & 64'hFFFF_FFFF;
    return mk(field, 1'b0);
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input int u);
    exp_t e;
    if (u == 0 && exp_q0.size() == 0 || u == 1 && exp_q1.size() == 0) begin
      checkValue($sformatf("unexpected_beat_u%0d", u), 64'(out_valid[u]), 64'd0);
      return;
    end
    e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    checkValue($sformatf("beat_data_u%0d", u), outData(u), e.data);
    checkValue($sformatf("beat_err_u%0d", u), 64'(out_err[u]), 64'(e.err));
  endtask

  task automatic applyStimulus(input int u, input logic [63:0] d, input int off, input int mode, input exp_t e);
    int waited;
    in_data[u]  = d;
    in_off[u]   = off[2:0];
    in_mode[u]  = mode[2:0];
    in_valid[u] = 1'b1;
    waited = 0;
    while (!in_ready[u] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[u]) begin
      checkValue($sformatf("accept_timeout_u%0d", u), 64'(in_ready[u]), 64'd1);
      in_valid[u] = 1'b0;
      return;
    end
    @(posedge clk);
    if (u == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  task automatic sendModel(input int u, input logic [63:0] d, input int off, input int mode);
    applyStimulus(u, d, off, mode, model(d, off, mode, (u == 0) ? 32 : 64));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkValue("drain_q0", 64'(exp_q0.size()), 64'd0);
    checkValue("drain_q1", 64'(exp_q1.size()), 64'd0);
  endtask

  task automatic randomRun(input int u, input int n);
    logic [63:0] d;
    int mode;
    int off;
    int size;
    int dw;
    dw = (u == 0) ? 32 : 64;
    for (int i = 0; i < n; i++) begin
      d    = {$urandom, $urandom};
      mode = $urandom_range(7);
      off  = $urandom_range(dw / 8 - 1);
      size = modeSize(mode, dw);
      if (size != 0 && $urandom_range(1) == 1) off = off - (off % size);
      sendModel(u, d, off, mode);
      if ($urandom_range(3) == 0) @(negedge clk);
    end
  endtask

  // Downstream ready pattern per instance: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) begin
      case (ready_mode[u])
        0:       out_ready[u] = 1'b1;
        1:       out_ready[u] = 1'($urandom_range(1));
        default: out_ready[u] = 1'b0;
      endcase
    end
  end

  // Monitor: compare delivered beats against the scoreboard and check stall stability.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        hold[u] = 1'b0;
      end else begin
        if (hold[u]) begin
          checkValue($sformatf("hold_valid_u%0d", u), 64'(out_valid[u]), 64'd1);
          checkValue($sformatf("hold_data_u%0d", u), outData(u), hold_data[u]);
          checkValue($sformatf("hold_err_u%0d", u), 64'(out_err[u]), 64'(hold_err[u]));
        end
        if (out_valid[u] && out_ready[u]) checkOutput(u);
        hold[u]      = out_valid[u] && !out_ready[u];
        hold_data[u] = outData(u);
        hold_err[u]  = out_err[u];
      end
    end
  end

  initial begin
    in_valid   = 2'b00;
    out_ready  = 2'b11;
    ready_mode = '{0, 0};
    for (int u = 0; u < 2; u++) begin
      in_data[u] = '0;
      in_off[u]  = '0;
      in_mode[u] = '0;
      hold[u]    = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      checkValue($sformatf("reset_out_valid_u%0d", u), 64'(out_valid[u]), 64'd0);
      checkValue($sformatf("reset_out_data_u%0d", u), outData(u), 64'd0);
      checkValue($sformatf("reset_out_err_u%0d", u), 64'(out_err[u]), 64'd0);
      checkValue($sformatf("reset_in_ready_u%0d", u), 64'(in_ready[u]), 64'd1);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed 32-bit extraction");
    applyStimulus(0, 64'h80FF_1234, 3, 0, mk(64'hFFFF_FF80, 1'b0));
    checkValue("latency_valid", 64'(out_valid[0]), 64'd1);
    checkValue("latency_data", 64'(out_data32), 64'hFFFF_FF80);
    applyStimulus(0, 64'h8001_0000, 2, 3, mk(64'h0000_8001, 1'b0));
    applyStimulus(0, 64'h8001_0000, 2, 2, mk(64'hFFFF_8001, 1'b0));
    applyStimulus(0, 64'hDEAD_BEEF, 1, 2, mk(64'h0, 1'b1));
    applyStimulus(0, 64'hDEAD_BEEF, 2, 4, mk(64'h0, 1'b1));
    applyStimulus(0, 64'hDEAD_BEEF, 0, 7, mk(64'h0, 1'b1));
    applyStimulus(0, 64'hCAFE_F00D, 0, 6, mk(64'hCAFE_F00D, 1'b0));
    waitDrain();

    $display("[TB] backpressure through the skid entry");
    ready_mode[0] = 2;
    repeat (2) @(negedge clk);
    applyStimulus(0, 64'h1122_3344, 0, 6, mk(64'h1122_3344, 1'b0));
    applyStimulus(0, 64'h0000_ABCD, 0, 2, mk(64'hFFFF_ABCD, 1'b0));
    checkValue("skid_in_ready_low", 64'(in_ready[0]), 64'd0);
    checkValue("stall_out_data", 64'(out_data32), 64'h1122_3344);
    fork
      applyStimulus(0, 64'h7F00_0000, 3, 1, mk(64'h0000_007F, 1'b0));
      begin
        repeat (3) begin
          checkValue("skid_hold_in_ready", 64'(in_ready[0]), 64'd0);
          @(negedge clk);
        end
        ready_mode[0] = 0;
      end
    join
    waitDrain();

    $display("[TB] directed 64-bit extraction");
    applyStimulus(1, 64'h8765_4321_0000_0000, 4, 4, mk(64'hFFFF_FFFF_8765_4321, 1'b0));
    applyStimulus(1, 64'h8765_4321_0000_0000, 4, 5, mk(64'h0000_0000_8765_4321, 1'b0));
    applyStimulus(1, 64'h0123_4567_89AB_CDEF, 0, 6, mk(64'h0123_4567_89AB_CDEF, 1'b0));
    applyStimulus(1, 64'h0123_4567_89AB_CDEF, 4, 6, mk(64'h0, 1'b1));
    applyStimulus(1, 64'h0123_4567_89AB_CDEF, 7, 1, mk(64'h0000_0000_0000_0001, 1'b0));
    waitDrain();

    $display("[TB] reset with the skid entry full");
    ready_mode[0] = 2;
    repeat (2) @(negedge clk);
    sendModel(0, 64'h0000_5555, 0, 4);
    sendModel(0, 64'h0000_6666, 0, 4);
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    checkValue("rst_mid_out_valid", 64'(out_valid[0]), 64'd0);
    checkValue("rst_mid_out_data", 64'(out_data32), 64'd0);
    checkValue("rst_mid_out_err", 64'(out_err[0]), 64'd0);
    checkValue("rst_mid_in_ready", 64'(in_ready[0]), 64'd1);
    rst = 1'b0;
    ready_mode[0] = 0;
    @(negedge clk);
    applyStimulus(0, 64'h0000_00F0, 0, 0, mk(64'hFFFF_FFF0, 1'b0));
    waitDrain();

    $display("[TB] randomized traffic");
    ready_mode = '{1, 1};
    fork
      randomRun(0, 150);
      randomRun(1, 150);
    join
    ready_mode = '{0, 0};
    waitDrain();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
